// File: rtl/rand_chk.sv
// rand_chk: regenerates the per-lane LFSR data stream and checks received beats against it
module rand_chk #(
    parameter int DW = 32,
    parameter int RW = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic [RW-1:0] i_seed,
    input  logic          i_valid,
    input  logic [DW-1:0] i_data,
    output logic          o_active,
    output logic          o_mismatch,
    output logic          o_err,
    output logic [CW-1:0] o_beat_cnt,
    output logic [CW-1:0] o_err_cnt,
    output logic [DW-1:0] o_first_exp,
    output logic [DW-1:0] o_first_got
);
    localparam int RBN = DW / 8;
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CHECK = 1'b1;

    logic [0:0]    r_state;
    logic [DW-1:0] r_exp;
    logic          r_mismatch;
    logic          r_err;
    logic [CW-1:0] r_beat_cnt;
    logic [CW-1:0] r_err_cnt;
    logic [DW-1:0] r_first_exp;
    logic [DW-1:0] r_first_got;
    logic [DW-1:0] w_seed;
    logic [DW-1:0] w_next;
    logic          w_accept;
    logic          w_ne;

    genvar d;
    generate
        for (d = 0; d < RBN; d++) begin : g_lane
            logic [RW-1:0] w_sum;
            assign w_sum = i_seed + RW'(d);
            // an all-zero byte would lock the lane LFSR, so it is replaced by FF
            assign w_seed[8*d +: 8] = (w_sum[7:0] == 8'h00) ? 8'hFF : w_sum[7:0];
            assign w_next[8*d +: 8] = {r_exp[8*d +: 7],
                                       r_exp[8*d+7] ^ r_exp[8*d+5] ^ r_exp[8*d+4] ^ r_exp[8*d+3]};
        end
    endgenerate

    assign w_accept = (r_state == S_CHECK) && i_valid;
    assign w_ne     = i_data != r_exp;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_exp       <= {DW{1'b1}};
            r_mismatch  <= 1'b0;
            r_err       <= 1'b0;
            r_beat_cnt  <= '0;
            r_err_cnt   <= '0;
            r_first_exp <= '0;
            r_first_got <= '0;
        end else if (i_load) begin
            r_state     <= S_CHECK;
            r_exp       <= w_seed;
            r_mismatch  <= 1'b0;
            r_err       <= 1'b0;
            r_beat_cnt  <= '0;
            r_err_cnt   <= '0;
            r_first_exp <= '0;
            r_first_got <= '0;
        end else if (w_accept) begin
            r_exp      <= w_next;
            r_mismatch <= w_ne;
            r_beat_cnt <= r_beat_cnt + CW'(!(&r_beat_cnt));
            if (w_ne) begin
                r_err     <= 1'b1;
                r_err_cnt <= r_err_cnt + CW'(!(&r_err_cnt));
                if (!r_err) begin
                    r_first_exp <= r_exp;
                    r_first_got <= i_data;
                end
            end
        end else begin
            r_mismatch <= 1'b0;
        end
    end

    assign o_active    = r_state == S_CHECK;
    assign o_mismatch  = r_mismatch;
    assign o_err       = r_err;
    assign o_beat_cnt  = r_beat_cnt;
    assign o_err_cnt   = r_err_cnt;
    assign o_first_exp = r_first_exp;
    assign o_first_got = r_first_got;
endmodule
